// File: rtl/spi_transaction_fsm.sv
// SPI memory-path transaction controller: address/R-W capture, then one read or write.
// Optional abort pulse output enabled by defining SPI_FSM_ABORT_FLAG_EN.
module spi_transaction_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs_n,
    input  logic             sclk_pe,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-2:0] addr,
    output logic             addr_we,
    output logic             dm_we,
    output logic             sr_we,
    output logic             miso_buff_en,
`ifdef SPI_FSM_ABORT_FLAG_EN
    output logic             abort,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] GET_ADDR    = 3'd1;
    localparam logic [2:0] GOT_ADDR    = 3'd2;
    localparam logic [2:0] READ_LOAD   = 3'd3;
    localparam logic [2:0] READ_SEND   = 3'd4;
    localparam logic [2:0] WRITE_RECV  = 3'd5;
    localparam logic [2:0] WRITE_STORE = 3'd6;
    localparam logic [2:0] DONE        = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        // Chip-select release overrides everything, including a terminal pulse.
        if (state_q != IDLE && cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cs_n) begin
                        state_d = GET_ADDR;
                        cnt_d   = '0;
                    end
                end
                GET_ADDR, READ_SEND, WRITE_RECV: begin
                    if (sclk_pe) begin
                        if (cnt_q == LAST) begin
                            cnt_d = '0;
                            if (state_q == GET_ADDR)       state_d = GOT_ADDR;
                            else if (state_q == READ_SEND) state_d = DONE;
                            else                           state_d = WRITE_STORE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                GOT_ADDR: begin
                    addr_d  = parallel_in[WIDTH-1:1];
                    cnt_d   = '0;
                    state_d = parallel_in[0] ? READ_LOAD : WRITE_RECV;
                end
                READ_LOAD: begin
                    cnt_d   = '0;
                    state_d = READ_SEND;
                end
                WRITE_STORE: state_d = DONE;
                DONE:        state_d = DONE;
                default:     state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

`ifdef SPI_FSM_ABORT_FLAG_EN
    logic abort_q, abort_d;

    always_comb begin
        abort_d = cs_n && (state_q != IDLE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) abort_q <= 1'b0;
        else          abort_q <= abort_d;
    end

    assign abort = abort_q;
`endif

    always_comb begin
        addr         = addr_q;
        addr_we      = (state_q == GOT_ADDR);
        sr_we        = (state_q == READ_LOAD);
        miso_buff_en = (state_q == READ_SEND);
        dm_we        = (state_q == WRITE_STORE);
        busy         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Randomized transaction bench for spi_transaction_fsm; expected outputs come from
// the transaction rules (pulse counts, fixed post-address latencies, abort priority).
module tb_spi_transaction_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cs_n;
    logic         sclk_pe;
    logic [W-1:0] parallel_in;
    logic [W-2:0] addr;
    logic         addr_we, dm_we, sr_we, miso_buff_en, busy;
`ifdef SPI_FSM_ABORT_FLAG_EN
    logic         abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-2:0] exp_addr;
    logic         exp_abort;

    spi_transaction_fsm #(.WIDTH(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cs_n(cs_n),
        .sclk_pe(sclk_pe),
        .parallel_in(parallel_in),
        .addr(addr),
        .addr_we(addr_we),
        .dm_we(dm_we),
        .sr_we(sr_we),
        .miso_buff_en(miso_buff_en),
`ifdef SPI_FSM_ABORT_FLAG_EN
        .abort(abort),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic a_we, input logic d_we,
                               input logic s_we, input logic miso, input logic bsy);
        check_eq({tag, ".addr_we"}, 32'(addr_we), 32'(a_we));
        check_eq({tag, ".dm_we"},   32'(dm_we),   32'(d_we));
        check_eq({tag, ".sr_we"},   32'(sr_we),   32'(s_we));
        check_eq({tag, ".miso"},    32'(miso_buff_en), 32'(miso));
        check_eq({tag, ".busy"},    32'(busy),    32'(bsy));
        check_eq({tag, ".addr"},    32'(addr),    32'(exp_addr));
`ifdef SPI_FSM_ABORT_FLAG_EN
        check_eq({tag, ".abort"},   32'(abort),   32'(exp_abort));
`endif
    endtask

    // One clock: apply inputs, let the edge happen, sample 1 time unit later.
    task automatic cyc(input logic cs, input logic pe);
        cs_n    = cs;
        sclk_pe = pe;
        @(posedge clk);
        #1;
        sclk_pe = 1'b0;
    endtask

    task automatic do_abort(input string tag);
        cyc(1'b1, 1'($urandom_range(0, 1)));
        exp_abort = 1'b1;
        expect_outs({tag, "_abort"}, 0, 0, 0, 0, 0);
        exp_abort = 1'b0;
        cyc(1'b1, 1'b0);
        expect_outs({tag, "_after"}, 0, 0, 0, 0, 0);
    endtask

    // abort_at: 0..2W-1 raises cs_n in that pulse slot, 99 raises it in the address
    // capture cycle, -1 runs to completion. extra: pulses delivered while holding DONE.
    task automatic txn(input logic [W-1:0] pin, input int abort_at, input bit noisy,
                       input int extra);
        int  slot    = 0;
        bit  is_read = pin[0];
        parallel_in = pin;
        cyc(1'b0, 1'b0);
        expect_outs("start", 0, 0, 0, 0, 1);
        for (int ph = 0; ph < 2; ph++) begin
            for (int p = 0; p < W; p++) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    cyc(1'b0, 1'b0);
                    expect_outs("gap", 0, 0, 0, 1'(ph == 1 && is_read), 1);
                end
                if (slot == abort_at) begin
                    do_abort("slot");
                    return;
                end
                cyc(1'b0, 1'b1);
                slot++;
                if (p < W - 1) expect_outs("count", 0, 0, 0, 1'(ph == 1 && is_read), 1);
            end
            if (ph == 0) begin
                expect_outs("got_addr", 1, 0, 0, 0, 1);
                if (abort_at == 99) begin
                    do_abort("got");
                    return;
                end
                cyc(1'b0, 1'(noisy));
                exp_addr = pin[W-1:1];
                if (is_read) begin
                    expect_outs("read_load", 0, 0, 1, 0, 1);
                    cyc(1'b0, 1'(noisy));
                    expect_outs("read_send", 0, 0, 0, 1, 1);
                end else begin
                    expect_outs("write_recv", 0, 0, 0, 0, 1);
                end
            end else if (is_read) begin
                expect_outs("read_done", 0, 0, 0, 0, 1);
            end else begin
                expect_outs("write_store", 0, 1, 0, 0, 1);
                cyc(1'b0, 1'(noisy));
                expect_outs("write_done", 0, 0, 0, 0, 1);
            end
        end
        for (int e = 0; e < extra; e++) begin
            cyc(1'b0, 1'b1);
            expect_outs("done_hold", 0, 0, 0, 0, 1);
        end
        cyc(1'b1, 1'b0);
        expect_outs("release", 0, 0, 0, 0, 0);
        cyc(1'b1, 1'b1);
        expect_outs("idle_pe", 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        cs_n        = 1'b1;
        sclk_pe     = 1'b0;
        parallel_in = '0;
        exp_addr    = '0;
        exp_abort   = 1'b0;
        @(posedge clk);
        #1;
        expect_outs("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        expect_outs("post_reset", 0, 0, 0, 0, 0);

        // Async reset while receiving write data.
        parallel_in = 8'h2A;
        cyc(1'b0, 1'b0);
        for (int i = 0; i < W; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        exp_addr = 7'h15;
        repeat (3) cyc(1'b0, 1'b1);
        expect_outs("in_write_recv", 0, 0, 0, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        exp_addr = '0;
        expect_outs("async_reset", 0, 0, 0, 0, 0);
        #1;
        cs_n = 1'b1;
        reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        expect_outs("reset_idle", 0, 0, 0, 0, 0);

        txn(8'h2A, -1, 1'b0, 0);
        check_eq("write_addr", 32'(addr), 32'h15);
        txn(8'h2B, -1, 1'b1, 0);
        check_eq("read_addr", 32'(addr), 32'h15);
        txn(8'hF1, 3, 1'b0, 0);
        txn(8'hC5, -1, 1'b1, 16);
        txn(8'h7E, 7, 1'b0, 0);
        txn(8'h81, 15, 1'b0, 0);
        txn(8'h40, 99, 1'b0, 0);
        txn(8'h93, -1, 1'b0, 2);

        for (int t = 0; t < 40; t++) begin
            int ab = -1;
            case ($urandom_range(0, 5))
                0: ab = $urandom_range(0, 2 * W - 1);
                1: ab = 99;
                default: ab = -1;
            endcase
            txn(W'($urandom), ab, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
